// File: rtl/mac_crc_pkg.sv
// CRC-32 (IEEE 802.3, reflected) constants, FSM state type and byte-step helper
// shared by the receive FCS checker.
package mac_crc_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } rx_state_t;

  // One byte through the reflected CRC-32 register, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int unsigned k = 0; k < 8; k++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/mac_crc32_lanes.sv
// Combinational CRC-32 update over one beat: lanes 0..nbytes-1 are applied in
// wire order, lanes at or above nbytes leave the register untouched.
module mac_crc32_lanes
  import mac_crc_pkg::*;
#(
  parameter int DATA_BYTES = 1
) (
  input  logic [31:0]                 crc_in,
  input  logic [8*DATA_BYTES-1:0]     data,
  input  logic [$clog2(DATA_BYTES):0] nbytes,
  output logic [31:0]                 crc_nxt
);

  logic [31:0] c;

  // Chain the byte step across lanes, skipping masked lanes.
  always_comb begin
    c = crc_in;
    for (int unsigned i = 0; i < DATA_BYTES; i++) begin
      if (i < 32'(nbytes)) begin
        c = crc32_byte(c, data[8*i +: 8]);
      end
    end
    crc_nxt = c;
  end

endmodule

// File: rtl/mac_fcs_check_rx.sv
// Receive-side Ethernet FCS checker: runs CRC-32 over the whole frame including
// the FCS, and at end of frame reports residue verdict, length and runt flag.
module mac_fcs_check_rx
  import mac_crc_pkg::*;
#(
  parameter int DATA_BYTES = 1,
  parameter int MIN_LEN    = 64,
  parameter int LEN_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic                        in_sof,
  input  logic                        in_eof,
  input  logic [8*DATA_BYTES-1:0]     in_data,
  input  logic [$clog2(DATA_BYTES):0] in_nbytes,
  output logic [31:0]                 crc_out,
  output logic                        done,
  output logic                        fcs_ok,
  output logic                        runt,
  output logic [LEN_W-1:0]            frame_len,
  output logic                        abort
);

  localparam int                 NB_W      = $clog2(DATA_BYTES) + 1;
  localparam logic [NB_W-1:0]    FULL_BEAT = NB_W'(DATA_BYTES);
  localparam logic [LEN_W:0]     MIN_LEN_X = (LEN_W+1)'(MIN_LEN);

  rx_state_t         state, state_nxt;
  logic [31:0]       crc_reg, crc_seed, crc_nxt;
  logic [LEN_W-1:0]  len_reg, len_base, len_nxt;
  logic [LEN_W:0]    len_sum;
  logic [NB_W-1:0]   beat_bytes;
  logic              start, cont, accept, finish, abort_nxt;
  logic              runt_nxt;

  // Valid bytes in this beat: only an eof beat may be partial, 0 means full.
  always_comb begin
    beat_bytes = FULL_BEAT;
    if (in_eof && (in_nbytes != '0) && (in_nbytes < FULL_BEAT)) begin
      beat_bytes = in_nbytes;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state and beat classification; a sof always (re)starts a frame.
  always_comb begin
    state_nxt = state;
    start     = in_valid && in_sof;
    cont      = in_valid && !in_sof && (state == ST_RUN);
    accept    = start || cont;
    finish    = accept && in_eof;
    abort_nxt = start && (state == ST_RUN);
    if (finish)      state_nxt = ST_IDLE;
    else if (accept) state_nxt = ST_RUN;
  end

  // Seed selection and saturating length accumulation.
  always_comb begin
    crc_seed = start ? CRC32_INIT : crc_reg;
    len_base = start ? '0 : len_reg;
    len_sum  = {1'b0, len_base} + (LEN_W+1)'(beat_bytes);
    len_nxt  = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];
    // Signed compare keeps MIN_LEN = 0 a plain (always false) test.
    runt_nxt = $signed({1'b0, len_nxt}) < $signed(MIN_LEN_X);
  end

  mac_crc32_lanes #(
    .DATA_BYTES (DATA_BYTES)
  ) u_lanes (
    .crc_in  (crc_seed),
    .data    (in_data),
    .nbytes  (beat_bytes),
    .crc_nxt (crc_nxt)
  );

  // Running CRC and length; both hold after eof until the next sof.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_reg <= CRC32_INIT;
      len_reg <= '0;
    end else if (accept) begin
      crc_reg <= crc_nxt;
      len_reg <= len_nxt;
    end
  end

  // Verdict registers and one-cycle done/abort pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      done      <= 1'b0;
      abort     <= 1'b0;
      fcs_ok    <= 1'b0;
      runt      <= 1'b0;
      frame_len <= '0;
    end else begin
      done  <= finish;
      abort <= abort_nxt;
      if (finish) begin
        fcs_ok    <= (crc_nxt == CRC32_RESIDUE);
        runt      <= runt_nxt;
        frame_len <= len_nxt;
      end
    end
  end

  assign crc_out = ~crc_reg;

endmodule

// File: tb/tb_mac_fcs_check_rx.sv
// Directed bench for mac_fcs_check_rx: a byte-wide instance (MIN_LEN 0) and a
// 4-byte instance (MIN_LEN 64); verdicts are scoreboarded against a queue.
module tb_mac_fcs_check_rx;

  localparam logic [31:0] POLY    = 32'hEDB88320;
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        v1, s1, e1;
  logic [7:0]  d1;
  logic [0:0]  nb1;
  logic [31:0] crc1;
  logic        done1, ok1, runt1, abort1;
  logic [15:0] len1;

  logic        v4, s4, e4;
  logic [31:0] d4;
  logic [2:0]  nb4;
  logic [31:0] crc4;
  logic        done4, ok4, runt4, abort4;
  logic [15:0] len4;

  typedef struct packed {
    logic        ok;
    logic        runt;
    logic [15:0] len;
  } exp_t;

  exp_t        q1[$], q4[$];
  exp_t        ex1, ex4;
  int          vectors = 0, miscompares = 0;
  int          abort_cnt1 = 0, abort_cnt4 = 0;
  logic [7:0]  fbuf[$];

  mac_fcs_check_rx #(.DATA_BYTES(1), .MIN_LEN(0), .LEN_W(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_sof(s1), .in_eof(e1),
    .in_data(d1), .in_nbytes(nb1), .crc_out(crc1), .done(done1),
    .fcs_ok(ok1), .runt(runt1), .frame_len(len1), .abort(abort1));

  mac_fcs_check_rx #(.DATA_BYTES(4), .MIN_LEN(64), .LEN_W(16)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_sof(s4), .in_eof(e4),
    .in_data(d4), .in_nbytes(nb4), .crc_out(crc4), .done(done4),
    .fcs_ok(ok4), .runt(runt4), .frame_len(len4), .abort(abort4));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bit-serial reference CRC register over the first n bytes of fbuf.
  function automatic logic [31:0] ref_crc(input int n);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ fbuf[i][k];
        c  = c >> 1;
        if (fb) c = c ^ POLY;
      end
    end
    return c;
  endfunction

  // n payload bytes base, base+1, ... followed by their FCS, LSB first.
  task automatic build(input int n, input logic [7:0] base);
    logic [31:0] fcs;
    fbuf.delete();
    for (int i = 0; i < n; i++) fbuf.push_back(base + 8'(i));
    fcs = ~ref_crc(n);
    for (int k = 0; k < 4; k++) fbuf.push_back(fcs[8*k +: 8]);
  endtask

  task automatic beat1(input logic sof, input logic eof, input logic [7:0] d, input logic [0:0] nb);
    @(negedge clk);
    v1 = 1'b1; s1 = sof; e1 = eof; d1 = d; nb1 = nb;
    v4 = 1'b0; s4 = 1'b0; e4 = 1'b0;
  endtask

  task automatic beat4(input logic sof, input logic eof, input logic [31:0] d, input logic [2:0] nb);
    @(negedge clk);
    v4 = 1'b1; s4 = sof; e4 = eof; d4 = d; nb4 = nb;
    v1 = 1'b0; s1 = 1'b0; e1 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      v1 = 1'b0; s1 = 1'b0; e1 = 1'b0;
      v4 = 1'b0; s4 = 1'b0; e4 = 1'b0;
    end
  endtask

  // Drive fbuf[from..to-1] as 4-byte beats; unused lanes carry filler.
  task automatic drive4(input int from, input int to, input bit sof_first, input bit eof_last);
    for (int i = from; i < to; i += 4) begin
      logic [31:0] w;
      int          cnt;
      w   = 32'hA5A5A5A5;
      cnt = (to - i < 4) ? (to - i) : 4;
      for (int j = 0; j < cnt; j++) w[8*j +: 8] = fbuf[i+j];
      beat4(sof_first && (i == from), eof_last && (i + 4 >= to), w, 3'(cnt));
    end
  endtask

  // Scoreboard monitors: every done pops one expected verdict.
  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      vectors++;
      assert (q1.size() != 0) else begin
        miscompares++;
        $error("FAIL done1_unexpected: observed done with %0d pending, expected none", q1.size());
      end
      if (q1.size() != 0) begin
        ex1 = q1.pop_front();
        check("dut1_fcs_ok", 32'(ok1), 32'(ex1.ok));
        check("dut1_runt", 32'(runt1), 32'(ex1.runt));
        check("dut1_frame_len", 32'(len1), 32'(ex1.len));
      end
    end
    if (abort1 === 1'b1) abort_cnt1++;
  end

  always @(negedge clk) begin
    if (done4 === 1'b1) begin
      vectors++;
      assert (q4.size() != 0) else begin
        miscompares++;
        $error("FAIL done4_unexpected: observed done with %0d pending, expected none", q4.size());
      end
      if (q4.size() != 0) begin
        ex4 = q4.pop_front();
        check("dut4_fcs_ok", 32'(ok4), 32'(ex4.ok));
        check("dut4_runt", 32'(runt4), 32'(ex4.runt));
        check("dut4_frame_len", 32'(len4), 32'(ex4.len));
      end
    end
    if (abort4 === 1'b1) abort_cnt4++;
  end

  initial begin
    rst = 1'b1;
    v1 = 1'b0; s1 = 1'b0; e1 = 1'b0; d1 = '0; nb1 = '0;
    v4 = 1'b0; s4 = 1'b0; e4 = 1'b0; d4 = '0; nb4 = '0;
    repeat (3) @(negedge clk);

    check("rst_crc1", crc1, 32'h0);
    check("rst_done1", 32'(done1), 32'h0);
    check("rst_ok1", 32'(ok1), 32'h0);
    check("rst_runt1", 32'(runt1), 32'h0);
    check("rst_len1", 32'(len1), 32'h0);
    check("rst_abort1", 32'(abort1), 32'h0);
    check("rst_crc4", crc4, 32'h0);
    check("rst_len4", 32'(len4), 32'h0);
    check("rst_abort4", 32'(abort4), 32'h0);
    rst = 1'b0;
    idle(2);

    // Beat without sof while idle is dropped.
    beat1(1'b0, 1'b1, 8'h55, 1'b1);
    idle(2);
    check("idle_drop1_crc", crc1, 32'h0);

    // "123456789" check value, then FCS bytes to close the frame.
    for (int i = 0; i < 9; i++) beat1(i == 0, 1'b0, 8'h31 + 8'(i), 1'b1);
    idle(1);
    check("crc_123456789", crc1, 32'hCBF43926);
    q1.push_back({1'b1, 1'b0, 16'd13});
    beat1(1'b0, 1'b0, 8'h26, 1'b1);
    beat1(1'b0, 1'b0, 8'h39, 1'b1);
    beat1(1'b0, 1'b0, 8'hF4, 1'b1);
    beat1(1'b0, 1'b1, 8'hCB, 1'b0);
    idle(3);
    check("crc_hold_after_good", crc1, ~RESIDUE);

    // Same frame with a corrupted last FCS byte.
    q1.push_back({1'b0, 1'b0, 16'd13});
    for (int i = 0; i < 9; i++) beat1(i == 0, 1'b0, 8'h31 + 8'(i), 1'b1);
    beat1(1'b0, 1'b0, 8'h26, 1'b1);
    beat1(1'b0, 1'b0, 8'h39, 1'b1);
    beat1(1'b0, 1'b0, 8'hF4, 1'b1);
    beat1(1'b0, 1'b1, 8'hCA, 1'b1);
    idle(3);

    // 64-byte frame, full last beat; 65-byte frame, one byte in last beat.
    build(60, 8'h00);
    q4.push_back({1'b1, 1'b0, 16'd64});
    drive4(0, 64, 1'b1, 1'b1);
    idle(3);
    build(61, 8'h00);
    q4.push_back({1'b1, 1'b0, 16'd65});
    drive4(0, 65, 1'b1, 1'b1);
    idle(3);

    // sof after 20 bytes of an open frame: abort, then the new frame completes.
    build(60, 8'h00);
    drive4(0, 20, 1'b1, 1'b0);
    build(60, 8'h80);
    q4.push_back({1'b1, 1'b0, 16'd64});
    drive4(0, 64, 1'b1, 1'b1);
    idle(3);
    check("abort_count4", 32'(abort_cnt4), 32'd1);

    // Single sof+eof beat with three bytes: runt, judged by residue.
    fbuf.delete();
    fbuf.push_back(8'h01); fbuf.push_back(8'h02); fbuf.push_back(8'h03);
    q4.push_back({ref_crc(3) == RESIDUE, 1'b1, 16'd3});
    drive4(0, 3, 1'b1, 1'b1);
    idle(3);
    // Non-sof beat in idle is ignored; final CRC stays readable.
    beat4(1'b0, 1'b0, 32'h11223344, 3'd4);
    idle(2);
    check("crc_hold_after_runt", crc4, ~ref_crc(3));

    // Reset mid-frame: silent discard; the rest of that frame is then ignored.
    build(60, 8'h00);
    drive4(0, 12, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1; v4 = 1'b0; s4 = 1'b0; e4 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    check("rst_mid_crc4", crc4, 32'h0);
    check("rst_mid_len4", 32'(len4), 32'h0);
    drive4(12, 64, 1'b0, 1'b1);
    idle(3);
    check("rst_mid_tail_ignored", crc4, 32'h0);
    check("abort_count4_final", 32'(abort_cnt4), 32'd1);
    check("abort_count1_final", 32'(abort_cnt1), 32'd0);

    idle(5);
    check("q1_drained", 32'(q1.size()), 32'd0);
    check("q4_drained", 32'(q4.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
